// File: rtl/mo_line_buffer_pp.sv
// Ping-pong motion-object line buffer: one bank is composited by the pixel writer,
// the other is streamed out and cleared behind the read pointer.
module mo_line_buffer_pp #(
    parameter int               PIX_W       = 8,
    parameter int               ADDR_W      = 9,
    parameter int               LINE_LEN    = 336,
    parameter logic [PIX_W-1:0] TRANSP_MASK = 8'h0F,
    parameter int               PRI_MODE    = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              line_start,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_x,
    input  logic              wr_en,
    input  logic [PIX_W-1:0]  wr_pix,
    input  logic              rd_en,
    output logic [PIX_W-1:0]  rd_pix,
    output logic              rd_valid,
    output logic              init_done,
    output logic              bank_sel,
    output logic              ovf,
    output logic              state_dbg
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W + 1)'(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LINE_LEN - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_q;
    logic              init_q;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] wr_x_q, wr_x_d;
    logic [ADDR_W-1:0] rd_x_q, rd_x_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    logic [PIX_W-1:0] mem_a [DEPTH];
    logic [PIX_W-1:0] mem_b [DEPTH];

    logic              run, swap, rbank, wbank;
    logic [ADDR_W-1:0] wx, rx;
    logic              w_in, r_in, w_do, r_do;
    logic [PIX_W-1:0]  w_old, r_cur;
    logic              new_opaque, old_transp;

    // A line_start swap takes effect before any same-cycle load, write or read.
    assign run        = (state_q == S_RUN);
    assign swap       = run & line_start;
    assign rbank      = bank_q ^ swap;
    assign wbank      = ~rbank;
    assign wx         = (run & ld) ? ld_x : (swap ? '0 : wr_x_q);
    assign rx         = swap ? '0 : rd_x_q;
    assign w_in       = ({1'b0, wx} < LEN_C);
    assign r_in       = ({1'b0, rx} < LEN_C);
    assign w_old      = wbank ? mem_b[wx] : mem_a[wx];
    assign r_cur      = rbank ? mem_b[rx] : mem_a[rx];
    assign new_opaque = ((wr_pix & TRANSP_MASK) != '0);
    assign old_transp = ((w_old & TRANSP_MASK) == '0);
    assign w_do       = run & wr_en & w_in & new_opaque & (old_transp | (PRI_MODE != 0));
    assign r_do       = run & rd_en & r_in;

    always_comb begin
        bank_d  = rbank;
        wr_x_d  = wx;
        rd_x_d  = rx;
        ovf_d   = ovf_q & ~swap;
        valid_d = run & rd_en;
        pix_d   = pix_q;
        if (run && wr_en) begin
            wr_x_d = wx + 1'b1;
            if (!w_in) ovf_d = 1'b1;
        end
        if (run && rd_en) begin
            pix_d = r_in ? r_cur : '0;
            if (r_in) rd_x_d = rx + 1'b1;
        end
    end

    // One access per bank per cycle: the sweep hits both, otherwise the write
    // bank takes the composite and the read bank takes the clear-behind.
    logic              a_we, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [PIX_W-1:0]  a_din, b_din;

    always_comb begin
        a_we   = 1'b0;
        b_we   = 1'b0;
        a_addr = '0;
        b_addr = '0;
        a_din  = '0;
        b_din  = '0;
        if (!run) begin
            a_we   = 1'b1;
            b_we   = 1'b1;
            a_addr = clr_q;
            b_addr = clr_q;
        end else begin
            if (w_do) begin
                if (wbank) begin
                    b_we = 1'b1; b_addr = wx; b_din = wr_pix;
                end else begin
                    a_we = 1'b1; a_addr = wx; a_din = wr_pix;
                end
            end
            if (r_do) begin
                if (rbank) begin
                    b_we = 1'b1; b_addr = rx;
                end else begin
                    a_we = 1'b1; a_addr = rx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_din;
        if (b_we) mem_b[b_addr] <= b_din;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
            init_q  <= 1'b0;
            bank_q  <= 1'b0;
            wr_x_q  <= '0;
            rd_x_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == LAST_C) begin
                        state_q <= S_RUN;
                        init_q  <= 1'b1;
                    end
                end
                S_RUN:   init_q  <= 1'b1;
                default: state_q <= S_CLEAR;
            endcase
            bank_q  <= bank_d;
            wr_x_q  <= wr_x_d;
            rd_x_q  <= rd_x_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
        end
    end

    assign rd_pix    = pix_q;
    assign rd_valid  = valid_q;
    assign init_done = init_q;
    assign bank_sel  = bank_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// Bench for mo_line_buffer_pp: two instances (first-wins and last-wins priority)
// driven in lockstep and checked against an array-based line model.
module tb_mo_line_buffer_pp;

    localparam int         PIX_W    = 8;
    localparam int         ADDR_W   = 9;
    localparam int         LINE_LEN = 336;
    localparam logic [7:0] TMASK    = 8'h0F;

    logic              clk = 1'b0;
    logic              rst_b = 1'b1;
    logic              line_start = 1'b0, ld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [ADDR_W-1:0] ld_x = '0;
    logic [PIX_W-1:0]  wr_pix = '0;
    logic [PIX_W-1:0]  rd_pix0, rd_pix1;
    logic rd_valid0, rd_valid1, init_done0, init_done1;
    logic bank_sel0, bank_sel1, ovf0, ovf1, st0, st1;

    mo_line_buffer_pp #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .LINE_LEN(LINE_LEN),
                        .TRANSP_MASK(TMASK), .PRI_MODE(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .line_start(line_start), .ld(ld), .ld_x(ld_x),
        .wr_en(wr_en), .wr_pix(wr_pix), .rd_en(rd_en), .rd_pix(rd_pix0),
        .rd_valid(rd_valid0), .init_done(init_done0), .bank_sel(bank_sel0),
        .ovf(ovf0), .state_dbg(st0));

    mo_line_buffer_pp #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .LINE_LEN(LINE_LEN),
                        .TRANSP_MASK(TMASK), .PRI_MODE(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .line_start(line_start), .ld(ld), .ld_x(ld_x),
        .wr_en(wr_en), .wr_pix(wr_pix), .rd_en(rd_en), .rd_pix(rd_pix1),
        .rd_valid(rd_valid1), .init_done(init_done1), .bank_sel(bank_sel1),
        .ovf(ovf1), .state_dbg(st1));

    // clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: [priority mode][bank][column]
    logic [7:0] mmem [2][2][LINE_LEN];
    int         m_bank, m_rx, m_wx;
    bit         m_ovf, m_valid, m_run;
    logic [7:0] m_pix [2];
    logic [PIX_W-1:0] exp_q0[$];
    logic [PIX_W-1:0] exp_q1[$];

    logic [7:0] cap0 [LINE_LEN+4];
    logic [7:0] cap1 [LINE_LEN+4];
    logic       capv [LINE_LEN+4];

    function automatic bit opaque(input logic [7:0] p);
        return (p & TMASK) != 8'h00;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < LINE_LEN; c++) mmem[m][b][c] = 8'h00;
        m_bank = 0; m_rx = 0; m_wx = 0; m_ovf = 0; m_valid = 0; m_run = 0;
        m_pix[0] = 8'h00; m_pix[1] = 8'h00;
        exp_q0.delete(); exp_q1.delete();
    endtask

    // driver: apply one cycle of inputs, advance the model, settle 1 after the edge
    task automatic step(input bit ls, input bit l, input int lx, input bit we,
                        input logic [7:0] px, input bit re);
        line_start = ls; ld = l; ld_x = lx[ADDR_W-1:0]; wr_en = we; wr_pix = px; rd_en = re;
        @(posedge clk);
        if (m_run) begin
            if (ls) begin
                m_bank = 1 - m_bank; m_rx = 0; m_wx = 0; m_ovf = 0;
            end
            if (l) m_wx = lx;
            if (we) begin
                if (m_wx < LINE_LEN) begin
                    for (int m = 0; m < 2; m++)
                        if (opaque(px) && (!opaque(mmem[m][1-m_bank][m_wx]) || m == 1))
                            mmem[m][1-m_bank][m_wx] = px;
                end else begin
                    m_ovf = 1;
                end
                m_wx = (m_wx + 1) % (1 << ADDR_W);
            end
            m_valid = re;
            if (re) begin
                for (int m = 0; m < 2; m++)
                    m_pix[m] = (m_rx < LINE_LEN) ? mmem[m][m_bank][m_rx] : 8'h00;
                if (m_rx < LINE_LEN) begin
                    mmem[0][m_bank][m_rx] = 8'h00;
                    mmem[1][m_bank][m_rx] = 8'h00;
                    m_rx++;
                end
                exp_q0.push_back(m_pix[0]);
                exp_q1.push_back(m_pix[1]);
            end
        end
        #1;
        line_start = 0; ld = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic read_line(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 8'h00, 1);
            cap0[i] = rd_pix0; cap1[i] = rd_pix1; capv[i] = rd_valid0 & rd_valid1;
        end
    endtask

    function automatic logic [7:0] pop0();
        return (exp_q0.size() != 0) ? exp_q0.pop_front() : 8'hxx;
    endfunction
    function automatic logic [7:0] pop1();
        return (exp_q1.size() != 0) ? exp_q1.pop_front() : 8'hxx;
    endfunction

    task automatic test_reset();
        int cnt, bad;
        logic [7:0] e0, e1;
        rst_b = 1'b0;
        #2;
        tests++;
        if ({rd_pix0, rd_valid0, init_done0, bank_sel0, ovf0, st0} !== 13'h0) begin
            fails++; $display("FAIL reset_vals_m0: got %h exp 0", {rd_pix0, rd_valid0, init_done0, bank_sel0, ovf0, st0});
        end
        tests++;
        if ({rd_pix1, rd_valid1, init_done1, bank_sel1, ovf1, st1} !== 13'h0) begin
            fails++; $display("FAIL reset_vals_m1: got %h exp 0", {rd_pix1, rd_valid1, init_done1, bank_sel1, ovf1, st1});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        // inputs held active during the sweep must be ignored
        line_start = 1; rd_en = 1; wr_en = 1; wr_pix = 8'hFF;
        cnt = 0; bad = 0;
        while (cnt < 2 * LINE_LEN && !(init_done0 && init_done1)) begin
            @(posedge clk); #1;
            cnt++;
            if (rd_valid0 || rd_valid1 || bank_sel0 || bank_sel1 || ovf0) bad++;
        end
        line_start = 0; rd_en = 0; wr_en = 0; wr_pix = 8'h00;
        tests++;
        if (cnt !== LINE_LEN) begin
            fails++; $display("FAIL init_latency: got %0d cycles exp %0d", cnt, LINE_LEN);
        end
        tests++;
        if (bad !== 0 || st0 !== 1'b1 || st1 !== 1'b1) begin
            fails++; $display("FAIL clear_ignores_inputs: got %0d violations state %b%b exp 0 and 11", bad, st0, st1);
        end
        m_run = 1;
        step(1, 0, 0, 0, 8'h00, 0);
        tests++;
        if (bank_sel0 !== 1'b1 || bank_sel0 !== m_bank[0]) begin
            fails++; $display("FAIL first_swap_bank: got %b exp 1", bank_sel0);
        end
        read_line(LINE_LEN);
        for (int i = 0; i < LINE_LEN; i++) begin
            e0 = pop0(); e1 = pop1();
            tests++;
            if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== 8'h00 || cap1[i] !== 8'h00) begin
                fails++; $display("FAIL post_init_zero col%0d: got v=%b %h/%h exp v=1 00/00", i, capv[i], cap0[i], cap1[i]);
            end
        end
    endtask

    task automatic test_ping_pong();
        logic [7:0] e0, e1, dir;
        step(0, 1, 10, 0, 8'h00, 0);
        step(0, 0, 0, 1, 8'h31, 0);
        step(0, 0, 0, 1, 8'h32, 0);
        step(0, 0, 0, 1, 8'h33, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        read_line(LINE_LEN);
        for (int i = 0; i < LINE_LEN; i++) begin
            e0 = pop0(); e1 = pop1();
            dir = (i >= 10 && i <= 12) ? 8'(8'h31 + i - 10) : 8'h00;
            tests++;
            if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== dir || cap1[i] !== dir) begin
                fails++; $display("FAIL pingpong col%0d: got v=%b %h/%h exp v=1 %h", i, capv[i], cap0[i], cap1[i], dir);
            end
        end
        step(1, 0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        read_line(LINE_LEN);
        for (int i = 0; i < LINE_LEN; i++) begin
            e0 = pop0(); e1 = pop1();
            tests++;
            if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap0[i] !== 8'h00 || cap1[i] !== 8'h00) begin
                fails++; $display("FAIL read_clear col%0d: got %h/%h exp 00", i, cap0[i], cap1[i]);
            end
        end
    endtask

    task automatic test_composite();
        logic [7:0] e0, e1, d0, d1;
        step(0, 1, 20, 1, 8'h15, 0);
        step(0, 1, 20, 1, 8'h27, 0);
        step(0, 0, 0, 1, 8'h20, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        read_line(21);
        for (int i = 0; i < 21; i++) begin
            e0 = pop0(); e1 = pop1();
            d0 = (i == 20) ? 8'h15 : 8'h00;
            d1 = (i == 20) ? 8'h27 : 8'h00;
            tests++;
            if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== d0 || cap1[i] !== d1) begin
                fails++; $display("FAIL composite col%0d: got %h/%h exp %h/%h", i, cap0[i], cap1[i], d0, d1);
            end
        end
        step(0, 0, 0, 0, 8'h00, 0);
        tests++;
        if (rd_valid0 !== 1'b0 || rd_pix0 !== 8'h15 || rd_pix1 !== 8'h27 || rd_pix0 !== m_pix[0]) begin
            fails++; $display("FAIL idle_hold: got v=%b %h/%h exp v=0 15/27", rd_valid0, rd_pix0, rd_pix1);
        end
        read_line(LINE_LEN - 21 + 2);
        for (int i = 0; i < LINE_LEN - 21 + 2; i++) begin
            e0 = pop0(); e1 = pop1();
            tests++;
            if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== 8'h00 || cap1[i] !== 8'h00) begin
                fails++; $display("FAIL composite_tail col%0d: got v=%b %h/%h exp v=1 00", 21 + i, capv[i], cap0[i], cap1[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e0, e1, dir;
        step(0, 1, LINE_LEN - 1, 1, 8'h11, 0);
        tests++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            fails++; $display("FAIL ovf_last_col: got %b%b exp 00", ovf0, ovf1);
        end
        step(0, 0, 0, 1, 8'h11, 0);
        tests++;
        if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || ovf0 !== m_ovf) begin
            fails++; $display("FAIL ovf_set: got %b%b exp 11", ovf0, ovf1);
        end
        step(0, 0, 0, 0, 8'h00, 0);
        tests++;
        if (ovf0 !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky: got %b exp 1", ovf0);
        end
        step(1, 0, 0, 0, 8'h00, 0);
        tests++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            fails++; $display("FAIL ovf_clear_on_swap: got %b%b exp 00", ovf0, ovf1);
        end
        read_line(LINE_LEN);
        for (int i = 0; i < LINE_LEN; i++) begin
            e0 = pop0(); e1 = pop1();
            dir = (i == LINE_LEN - 1) ? 8'h11 : 8'h00;
            tests++;
            if (cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== dir || cap1[i] !== dir) begin
                fails++; $display("FAIL ovf_line col%0d: got %h/%h exp %h", i, cap0[i], cap1[i], dir);
            end
        end
        step(0, 1, (1 << ADDR_W) - 1, 1, 8'h22, 0);
        step(0, 0, 0, 1, 8'h23, 0);
        tests++;
        if (ovf0 !== 1'b1) begin
            fails++; $display("FAIL ovf_wrap_set: got %b exp 1", ovf0);
        end
        step(1, 0, 0, 0, 8'h00, 0);
        read_line(2);
        for (int i = 0; i < 2; i++) begin
            e0 = pop0(); e1 = pop1();
            dir = (i == 0) ? 8'h23 : 8'h00;
            tests++;
            if (cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== dir || cap1[i] !== dir) begin
                fails++; $display("FAIL wrap_col%0d: got %h/%h exp %h", i, cap0[i], cap1[i], dir);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic       prev;
        logic [7:0] e0, e1, dir;
        step(0, 1, 0, 1, 8'h5A, 0);
        prev = bank_sel0;
        step(1, 1, 5, 1, 8'h41, 1);
        e0 = pop0(); e1 = pop1();
        tests++;
        if (bank_sel0 !== ~prev || bank_sel1 !== ~prev || bank_sel0 !== m_bank[0]) begin
            fails++; $display("FAIL sim_bank_toggle: got %b exp %b", bank_sel0, ~prev);
        end
        tests++;
        if (rd_valid0 !== 1'b1 || rd_pix0 !== e0 || rd_pix1 !== e1 || rd_pix0 !== 8'h5A || rd_pix1 !== 8'h5A) begin
            fails++; $display("FAIL sim_read_col0: got v=%b %h/%h exp v=1 5a", rd_valid0, rd_pix0, rd_pix1);
        end
        step(1, 0, 0, 0, 8'h00, 0);
        read_line(8);
        for (int i = 0; i < 8; i++) begin
            e0 = pop0(); e1 = pop1();
            dir = (i == 5) ? 8'h41 : 8'h00;
            tests++;
            if (cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== dir || cap1[i] !== dir) begin
                fails++; $display("FAIL sim_write col%0d: got %h/%h exp %h", i, cap0[i], cap1[i], dir);
            end
        end
    endtask

    task automatic test_random();
        bit ls, l, we, re;
        int lx;
        logic [7:0] px, e0, e1;
        for (int n = 0; n < 3000; n++) begin
            ls = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            we = $urandom_range(0, 1) != 0;
            re = $urandom_range(0, 1) != 0;
            px = 8'($urandom);
            lx = ($urandom_range(0, 3) == 0) ? $urandom_range(LINE_LEN - 4, (1 << ADDR_W) - 1)
                                              : $urandom_range(0, 40);
            step(ls, l, lx, we, px, re);
            if (m_valid) begin
                e0 = pop0(); e1 = pop1();
            end else begin
                e0 = m_pix[0]; e1 = m_pix[1];
            end
            tests++;
            if (rd_valid0 !== m_valid || rd_valid1 !== m_valid || rd_pix0 !== e0 || rd_pix1 !== e1 ||
                bank_sel0 !== m_bank[0] || ovf0 !== m_ovf || ovf1 !== m_ovf) begin
                fails++;
                $display("FAIL random step%0d: got v=%b pix=%h/%h bank=%b ovf=%b exp v=%b pix=%h/%h bank=%b ovf=%b",
                         n, rd_valid0, rd_pix0, rd_pix1, bank_sel0, ovf0, m_valid, e0, e1, m_bank[0], m_ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        logic [7:0] e0, e1;
        step(1, 1, 0, 1, 8'h5F, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 8'($urandom) | 8'h01, 0);
        step(1, 1, 0, 1, 8'h6E, 1);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 8'($urandom) | 8'h01, 1);
        ld = 1; ld_x = 9'd200; wr_en = 1; wr_pix = 8'h77; rd_en = 1;
        @(posedge clk); #3;
        rst_b = 1'b0;
        #1;
        tests++;
        if ({rd_pix0, rd_valid0, init_done0, bank_sel0, ovf0, st0} !== 13'h0 ||
            {rd_pix1, rd_valid1, init_done1, bank_sel1, ovf1, st1} !== 13'h0) begin
            fails++; $display("FAIL async_reset_vals: got %h/%h exp 0/0",
                              {rd_pix0, rd_valid0, init_done0, bank_sel0, ovf0, st0},
                              {rd_pix1, rd_valid1, init_done1, bank_sel1, ovf1, st1});
        end
        ld = 0; wr_en = 0; rd_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        cnt = 0;
        while (cnt < 2 * LINE_LEN && !init_done0) begin
            @(posedge clk); #1;
            cnt++;
        end
        tests++;
        if (cnt !== LINE_LEN) begin
            fails++; $display("FAIL reinit_latency: got %0d cycles exp %0d", cnt, LINE_LEN);
        end
        m_run = 1;
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 0, 0, 8'h00, 0);
            read_line(LINE_LEN);
            for (int i = 0; i < LINE_LEN; i++) begin
                e0 = pop0(); e1 = pop1();
                tests++;
                if (capv[i] !== 1'b1 || cap0[i] !== e0 || cap1[i] !== e1 || cap0[i] !== 8'h00 || cap1[i] !== 8'h00) begin
                    fails++; $display("FAIL reinit_zero pass%0d col%0d: got v=%b %h/%h exp v=1 00", pass, i, capv[i], cap0[i], cap1[i]);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_ping_pong();
        test_composite();
        test_overflow();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
